// File: rtl/multi_key_debouncer.sv
// rtl/multi_key_debouncer.sv - CH_NUM-channel key debouncer with hysteresis, auto-repeat and release events
// Optional long-press detection is compiled in when DEBOUNCE_LONG_PRESS_EN is defined.
module multi_key_debouncer #(
    parameter int CH_NUM          = 4,
    parameter int FILT_BITS       = 4,
    parameter int REP_CNT_BITS    = 7,
    parameter int REP_START_DELAY = 99,
    parameter int REP_PERIOD      = 100,
    parameter int LONG_TICKS      = 200
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CE,
    input  logic              REP_EN,
    input  logic [CH_NUM-1:0] S_IN,
    input  logic [CH_NUM-1:0] REP_MASK,
    output logic [CH_NUM-1:0] KEY_EN,
    output logic [CH_NUM-1:0] KEY_UP,
    output logic [CH_NUM-1:0] KEY_DN
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    output logic [CH_NUM-1:0] KEY_LONG
`endif
);

    generate
        if (FILT_BITS < 2) begin : g_bad_filt
            $error("multi_key_debouncer: FILT_BITS must be >= 2");
        end
        if (REP_PERIOD < 1) begin : g_bad_period
            $error("multi_key_debouncer: REP_PERIOD must be >= 1");
        end
        if ((REP_START_DELAY >= (1 << REP_CNT_BITS)) || ((REP_PERIOD - 1) >= (1 << REP_CNT_BITS))) begin : g_bad_cnt
            $error("multi_key_debouncer: repeat reload values do not fit REP_CNT_BITS");
        end
        if (LONG_TICKS < 1) begin : g_bad_long
            $error("multi_key_debouncer: LONG_TICKS must be >= 1");
        end
    endgenerate

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    localparam logic [REP_CNT_BITS-1:0] START_CNT  = REP_CNT_BITS'(REP_START_DELAY);
    localparam logic [REP_CNT_BITS-1:0] PERIOD_CNT = REP_CNT_BITS'(REP_PERIOD - 1);

    logic   [FILT_BITS-1:0]    p_q     [CH_NUM];
    logic   [FILT_BITS-1:0]    p_d     [CH_NUM];
    state_t                    state_q [CH_NUM];
    state_t                    state_d [CH_NUM];
    logic   [REP_CNT_BITS-1:0] cnt_q   [CH_NUM];
    logic   [REP_CNT_BITS-1:0] cnt_d   [CH_NUM];
    logic   [CH_NUM-1:0]       key_up_q;
    logic   [CH_NUM-1:0]       key_up_d;
    logic   [CH_NUM-1:0]       key_dn_q;
    logic   [CH_NUM-1:0]       key_dn_d;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int                   LCNT_BITS = $clog2(LONG_TICKS + 1);
    localparam logic [LCNT_BITS-1:0] LONG_MAX  = LCNT_BITS'(LONG_TICKS);
    localparam logic [LCNT_BITS-1:0] LONG_LAST = LCNT_BITS'(LONG_TICKS - 1);

    logic [LCNT_BITS-1:0] lcnt_q [CH_NUM];
    logic [LCNT_BITS-1:0] lcnt_d [CH_NUM];
    logic [CH_NUM-1:0]    key_long_q;
    logic [CH_NUM-1:0]    key_long_d;
`endif

    always_comb begin
        key_up_d = '0;
        key_dn_d = '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
        key_long_d = '0;
`endif
        for (int i = 0; i < CH_NUM; i++) begin
            p_d[i]     = CE ? {p_q[i][FILT_BITS-2:0], S_IN[i]} : p_q[i];
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef DEBOUNCE_LONG_PRESS_EN
            lcnt_d[i]  = lcnt_q[i];
`endif
            case (state_q[i])
                RELEASED: begin
                    // The press cycle itself never consumes a repeat tick.
                    if (&p_q[i]) begin
                        state_d[i]  = PRESSED;
                        key_up_d[i] = 1'b1;
                        cnt_d[i]    = START_CNT;
`ifdef DEBOUNCE_LONG_PRESS_EN
                        lcnt_d[i]   = '0;
`endif
                    end
                end
                PRESSED: begin
                    if (~|p_q[i]) begin
                        state_d[i]  = RELEASED;
                        key_dn_d[i] = 1'b1;
                        cnt_d[i]    = '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
                        lcnt_d[i]   = '0;
`endif
                    end else begin
                        if (REP_MASK[i] && REP_EN) begin
                            if (cnt_q[i] == '0) begin
                                key_up_d[i] = 1'b1;
                                cnt_d[i]    = PERIOD_CNT;
                            end else begin
                                cnt_d[i] = cnt_q[i] - REP_CNT_BITS'(1);
                            end
                        end
`ifdef DEBOUNCE_LONG_PRESS_EN
                        // Saturating at LONG_MAX makes the long pulse fire once per press.
                        if (REP_EN && (lcnt_q[i] != LONG_MAX)) begin
                            lcnt_d[i] = lcnt_q[i] + LCNT_BITS'(1);
                            if (lcnt_q[i] == LONG_LAST) begin
                                key_long_d[i] = 1'b1;
                            end
                        end
`endif
                    end
                end
                default: state_d[i] = RELEASED;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < CH_NUM; i++) begin
                p_q[i]     <= '0;
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
                lcnt_q[i]  <= '0;
`endif
            end
            key_up_q <= '0;
            key_dn_q <= '0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            key_long_q <= '0;
`endif
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                p_q[i]     <= p_d[i];
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef DEBOUNCE_LONG_PRESS_EN
                lcnt_q[i]  <= lcnt_d[i];
`endif
            end
            key_up_q <= key_up_d;
            key_dn_q <= key_dn_d;
`ifdef DEBOUNCE_LONG_PRESS_EN
            key_long_q <= key_long_d;
`endif
        end
    end

    always_comb begin
        KEY_EN = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            KEY_EN[i] = (state_q[i] == PRESSED);
        end
    end

    assign KEY_UP = key_up_q;
    assign KEY_DN = key_dn_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
    assign KEY_LONG = key_long_q;
`endif

endmodule
